// File: rtl/rdp_systolic_pkg.sv
// ---------------------------------------------------------------------------
// rdp_systolic_pkg
//
// Shared constants and helpers for the systolic fork/join controllers.
//
// Contents:
//   DEF_N_OUT, DEF_DATA_W, DEF_CNT_W : default parameter values
//   MAX_N                            : widest branch vector the helpers take
//   onehot_all_done(pend, take)      : 1 when every owed branch is satisfied
//                                      by this cycle's takes
// ---------------------------------------------------------------------------
package rdp_systolic_pkg;

    localparam int DEF_N_OUT  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    // Branch vectors are zero-extended to this width before using the
    // helpers, so a single function serves every legal branch count (2..8).
    localparam int MAX_N = 8;

    // True when no branch remains owed after this cycle's takes.
    // Bits above the real branch count must be zero on both arguments.
    function automatic logic onehot_all_done(input logic [MAX_N-1:0] pend,
                                             input logic [MAX_N-1:0] take);
        return ((pend & ~take) == '0);
    endfunction

endpackage

// File: rtl/rdp_fork_lane.sv
// ---------------------------------------------------------------------------
// rdp_fork_lane
//
// One downstream branch of the eager fork. Holds the "still owed" bit for
// the current token and performs this branch's handshake.
//
// Ports:
//   clk       in  clock
//   reset_n   in  synchronous reset, active-high
//   valid     in  token slot occupied
//   load      in  a new token loads into the slot this edge
//   mask_bit  in  this branch's bit of the incoming token mask
//   ack       in  downstream accept for this branch
//   req       out downstream valid for this branch
//   take      out this branch transfers this cycle (req & ack)
//   pend      out raw owed bit (slot-level completion uses it)
// ---------------------------------------------------------------------------
module rdp_fork_lane (
    input  logic clk,
    input  logic reset_n,
    input  logic valid,
    input  logic load,
    input  logic mask_bit,
    input  logic ack,
    output logic req,
    output logic take,
    output logic pend
);

    logic pend_q;
    logic pend_d;

    // An ack while not requesting is simply ignored.
    assign req  = valid & pend_q;
    assign take = req & ack;
    assign pend = pend_q;

    // A new token overrides whatever is left of the old one. Otherwise the
    // owed bit clears once taken; when the slot completes every lane has
    // just been taken or was already clear, so it drops to 0 on its own.
    always_comb begin
        pend_d = pend_q;
        if (load) begin
            pend_d = mask_bit;
        end else if (valid) begin
            pend_d = pend_q & ~take;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/rdp_systolic_fork.sv
// ---------------------------------------------------------------------------
// rdp_systolic_fork
//
// Eager fork: accepts one upstream token and broadcasts it to N_OUT
// consumers. Each branch handshakes independently; the slot frees when every
// branch named in the token's mask has taken it. A new token can load on the
// same edge the previous one completes, giving one token per cycle.
//
// Parameters:
//   N_OUT   number of branches (2..8)
//   DATA_W  payload width
//   CNT_W   width of the delivered / dropped token counters
//
// Ports:
//   clk       in   clock
//   reset_n   in   synchronous reset, active-high (name kept for codebase)
//   t_req     in   upstream valid
//   t_ack     out  upstream accept (combinational from i_ack)
//   t_data    in   upstream payload
//   t_mask    in   branches that must receive the token
//   i_req     out  per-branch valid
//   i_ack     in   per-branch accept
//   i_data    out  registered payload, common to all branches
//   tok_cnt   out  fully delivered tokens (wraps)
//   drop_cnt  out  accepted tokens with an empty mask (wraps)
//   busy      out  token slot occupied
// ---------------------------------------------------------------------------
module rdp_systolic_fork
    import rdp_systolic_pkg::*;
#(
    parameter int N_OUT  = DEF_N_OUT,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              t_req,
    output logic              t_ack,
    input  logic [DATA_W-1:0] t_data,
    input  logic [N_OUT-1:0]  t_mask,
    output logic [N_OUT-1:0]  i_req,
    input  logic [N_OUT-1:0]  i_ack,
    output logic [DATA_W-1:0] i_data,
    output logic [CNT_W-1:0]  tok_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    // -----------------------------------------------------------------
    // Slot state
    // -----------------------------------------------------------------
    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [CNT_W-1:0]  tok_cnt_q;
    logic [CNT_W-1:0]  tok_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  drop_cnt_d;

    // -----------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------
    logic [N_OUT-1:0] take_w;
    logic [N_OUT-1:0] pend_w;
    logic             complete;
    logic             accept;
    logic             load;
    logic             drop;
    logic             mask_empty;

    // Completion is judged on the owed set after this cycle's takes, so a
    // token whose last branches all ack together frees the slot on that
    // same edge and t_ack can admit the next one immediately.
    assign complete   = valid_q &
                        onehot_all_done(MAX_N'(pend_w), MAX_N'(take_w));
    assign t_ack      = ~valid_q | complete;
    assign accept     = t_req & t_ack;
    assign mask_empty = (t_mask == '0);
    assign load       = accept & ~mask_empty;
    // An empty-mask token is acknowledged but never occupies the slot.
    assign drop       = accept & mask_empty;

    // -----------------------------------------------------------------
    // Per-branch lanes
    // -----------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
            rdp_fork_lane u_lane (
                .clk      (clk),
                .reset_n  (reset_n),
                .valid    (valid_q),
                .load     (load),
                .mask_bit (t_mask[gi]),
                .ack      (i_ack[gi]),
                .req      (i_req[gi]),
                .take     (take_w[gi]),
                .pend     (pend_w[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        tok_cnt_d  = tok_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (load) begin
            valid_d = 1'b1;
            data_d  = t_data;
        end else if (complete) begin
            // Payload is kept after completion; i_req is what gates it.
            valid_d = 1'b0;
        end

        // A completion that coincides with a new load still counts once.
        if (complete) begin
            tok_cnt_d = tok_cnt_q + CNT_W'(1);
        end

        if (drop) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            tok_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            tok_cnt_q  <= tok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign i_data   = data_q;
    assign tok_cnt  = tok_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = valid_q;

    // -----------------------------------------------------------------
    // Upstream must hold its offer steady while it is being stalled.
    // -----------------------------------------------------------------
    property p_upstream_stable;
        @(posedge clk) disable iff (reset_n)
        (t_req && !t_ack) |=> (t_req && (t_data == $past(t_data)) &&
                               (t_mask == $past(t_mask)));
    endproperty

    a_upstream_stable : assert property (p_upstream_stable);

endmodule

// File: tb/tb_rdp_systolic_fork.sv
// ---------------------------------------------------------------------------
// tb_rdp_systolic_fork
//
// Directed bench for the eager fork. Main instance uses the default widths;
// a second instance with a 4-bit counter shares all inputs to observe wrap.
// ---------------------------------------------------------------------------
module tb_rdp_systolic_fork;

    localparam int N_OUT  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int CNT_WS = 4;

    logic              clk;
    logic              reset_n;
    logic              t_req;
    logic              t_ack;
    logic [DATA_W-1:0] t_data;
    logic [N_OUT-1:0]  t_mask;
    logic [N_OUT-1:0]  i_req;
    logic [N_OUT-1:0]  i_ack;
    logic [DATA_W-1:0] i_data;
    logic [CNT_W-1:0]  tok_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              busy;

    logic              s_t_ack;
    logic [N_OUT-1:0]  s_i_req;
    logic [DATA_W-1:0] s_i_data;
    logic [CNT_WS-1:0] s_tok_cnt;
    logic [CNT_WS-1:0] s_drop_cnt;
    logic              s_busy;

    int errors = 0;
    int checks = 0;

    rdp_systolic_fork #(.N_OUT(N_OUT), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .t_req    (t_req),
        .t_ack    (t_ack),
        .t_data   (t_data),
        .t_mask   (t_mask),
        .i_req    (i_req),
        .i_ack    (i_ack),
        .i_data   (i_data),
        .tok_cnt  (tok_cnt),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    rdp_systolic_fork #(.N_OUT(N_OUT), .DATA_W(DATA_W), .CNT_W(CNT_WS)) dut_small (
        .clk      (clk),
        .reset_n  (reset_n),
        .t_req    (t_req),
        .t_ack    (s_t_ack),
        .t_data   (t_data),
        .t_mask   (t_mask),
        .i_req    (s_i_req),
        .i_ack    (i_ack),
        .i_data   (s_i_data),
        .tok_cnt  (s_tok_cnt),
        .drop_cnt (s_drop_cnt),
        .busy     (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are sampled
    // 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        t_req   = 1'b0;
        t_data  = '0;
        t_mask  = '0;
        i_ack   = '0;
        cyc();
        cyc();
        reset_n = 1'b0;
        #1;
        checks++; if (i_req !== 4'b0000) begin errors++; $display("FAIL reset_i_req got=%b exp=0000", i_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (tok_cnt !== 16'd0) begin errors++; $display("FAIL reset_tok got=%0d exp=0", tok_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        checks++; if (i_data !== 32'h0) begin errors++; $display("FAIL reset_i_data got=%h exp=0", i_data); end
        checks++; if (t_ack !== 1'b1) begin errors++; $display("FAIL reset_t_ack got=%b exp=1", t_ack); end
        $display("reset: i_req=%b busy=%b tok=%0d drop=%0d", i_req, busy, tok_cnt, drop_cnt);
    endtask

    task automatic test_full_rate();
        logic [31:0] exp_d;
        i_ack  = 4'b1111;
        t_mask = 4'b1111;
        t_req  = 1'b1;
        t_data = 32'hA0;
        #1;
        checks++; if (t_ack !== 1'b1) begin errors++; $display("FAIL fr_first_t_ack got=%b exp=1", t_ack); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            exp_d = 32'hA0 + 32'(k);
            if (k < 2) t_data = 32'hA1 + 32'(k);
            else       t_req  = 1'b0;
            #1;
            checks++; if (i_req !== 4'b1111) begin errors++; $display("FAIL fr_i_req[%0d] got=%b exp=1111", k, i_req); end
            checks++; if (i_data !== exp_d) begin errors++; $display("FAIL fr_i_data[%0d] got=%h exp=%h", k, i_data, exp_d); end
            checks++; if (t_ack !== 1'b1) begin errors++; $display("FAIL fr_t_ack[%0d] got=%b exp=1", k, t_ack); end
            checks++; if (tok_cnt !== 16'(k)) begin errors++; $display("FAIL fr_tok[%0d] got=%0d exp=%0d", k, tok_cnt, k); end
            $display("full_rate %0d: i_req=%b i_data=%h tok=%0d", k, i_req, i_data, tok_cnt);
        end
        cyc();
        checks++; if (tok_cnt !== 16'd3) begin errors++; $display("FAIL fr_tok_end got=%0d exp=3", tok_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fr_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_staggered();
        // ack pattern per waiting cycle and the i_req / t_ack expected there
        logic [3:0] ack_tab  [4] = '{4'b0001, 4'b0100, 4'b0101, 4'b1010};
        logic [3:0] req_tab  [4] = '{4'b1111, 4'b1110, 4'b1010, 4'b1010};
        logic       tack_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        i_ack  = 4'b0000;
        t_mask = 4'b1111;
        t_data = 32'hB0;
        t_req  = 1'b1;
        cyc();
        t_data = 32'hB1;   // next token offered and held while stalled
        for (int c = 0; c < 4; c++) begin
            i_ack = ack_tab[c];
            #1;
            checks++; if (i_req !== req_tab[c]) begin errors++; $display("FAIL st_i_req[%0d] got=%b exp=%b", c, i_req, req_tab[c]); end
            checks++; if (t_ack !== tack_tab[c]) begin errors++; $display("FAIL st_t_ack[%0d] got=%b exp=%b", c, t_ack, tack_tab[c]); end
            checks++; if (tok_cnt !== 16'd3) begin errors++; $display("FAIL st_tok[%0d] got=%0d exp=3", c, tok_cnt); end
            $display("staggered %0d: i_ack=%b i_req=%b t_ack=%b", c, i_ack, i_req, t_ack);
            cyc();
        end
        t_req = 1'b0;
        i_ack = 4'b0000;
        #1;
        checks++; if (i_req !== 4'b1111) begin errors++; $display("FAIL st_next_i_req got=%b exp=1111", i_req); end
        checks++; if (i_data !== 32'hB1) begin errors++; $display("FAIL st_next_i_data got=%h exp=b1", i_data); end
        checks++; if (tok_cnt !== 16'd4) begin errors++; $display("FAIL st_tok_after got=%0d exp=4", tok_cnt); end
        i_ack = 4'b1111;
        cyc();
        checks++; if (tok_cnt !== 16'd5) begin errors++; $display("FAIL st_tok_drain got=%0d exp=5", tok_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_busy_drain got=%b exp=0", busy); end
    endtask

    task automatic test_mask_partial();
        i_ack  = 4'b1111;
        t_mask = 4'b0101;
        t_data = 32'hC0;
        t_req  = 1'b1;
        cyc();
        t_req = 1'b0;
        #1;
        checks++; if (i_req !== 4'b0101) begin errors++; $display("FAIL mp_i_req got=%b exp=0101", i_req); end
        checks++; if (t_ack !== 1'b1) begin errors++; $display("FAIL mp_t_ack got=%b exp=1", t_ack); end
        $display("mask_partial: i_req=%b t_ack=%b", i_req, t_ack);
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mp_busy got=%b exp=0", busy); end
        checks++; if (i_req !== 4'b0000) begin errors++; $display("FAIL mp_i_req_after got=%b exp=0000", i_req); end
        checks++; if (tok_cnt !== 16'd6) begin errors++; $display("FAIL mp_tok got=%0d exp=6", tok_cnt); end
    endtask

    task automatic test_drop();
        i_ack  = 4'b0000;
        t_mask = 4'b0000;
        t_data = 32'hDD;
        t_req  = 1'b1;
        #1;
        checks++; if (t_ack !== 1'b1) begin errors++; $display("FAIL dr_t_ack got=%b exp=1", t_ack); end
        cyc();
        t_req = 1'b0;
        #1;
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL dr_drop got=%0d exp=1", drop_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dr_busy got=%b exp=0", busy); end
        checks++; if (tok_cnt !== 16'd6) begin errors++; $display("FAIL dr_tok got=%0d exp=6", tok_cnt); end
        checks++; if (i_data !== 32'hC0) begin errors++; $display("FAIL dr_i_data got=%h exp=c0", i_data); end
        $display("drop: drop=%0d busy=%b tok=%0d", drop_cnt, busy, tok_cnt);
    endtask

    task automatic test_reset_mid();
        i_ack  = 4'b0000;
        t_mask = 4'b1111;
        t_data = 32'hD0;
        t_req  = 1'b1;
        cyc();
        t_req = 1'b0;
        i_ack = 4'b1100;
        cyc();
        i_ack = 4'b0000;
        #1;
        checks++; if (i_req !== 4'b0011) begin errors++; $display("FAIL rm_pend got=%b exp=0011", i_req); end
        reset_n = 1'b1;
        cyc();
        reset_n = 1'b0;
        #1;
        checks++; if (i_req !== 4'b0000) begin errors++; $display("FAIL rm_i_req got=%b exp=0000", i_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        checks++; if (tok_cnt !== 16'd0) begin errors++; $display("FAIL rm_tok got=%0d exp=0", tok_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rm_drop got=%0d exp=0", drop_cnt); end
        $display("reset_mid: i_req=%b busy=%b tok=%0d drop=%0d", i_req, busy, tok_cnt, drop_cnt);
        t_mask = 4'b1000;
        t_data = 32'hE0;
        t_req  = 1'b1;
        cyc();
        t_req = 1'b0;
        #1;
        checks++; if (i_req !== 4'b1000) begin errors++; $display("FAIL rm_new_i_req got=%b exp=1000", i_req); end
        checks++; if (i_data !== 32'hE0) begin errors++; $display("FAIL rm_new_i_data got=%h exp=e0", i_data); end
        i_ack = 4'b1000;
        #1;
        checks++; if (t_ack !== 1'b1) begin errors++; $display("FAIL rm_new_t_ack got=%b exp=1", t_ack); end
        cyc();
        checks++; if (tok_cnt !== 16'd1) begin errors++; $display("FAIL rm_new_tok got=%0d exp=1", tok_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_new_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_w;
        reset_n = 1'b1;
        t_req   = 1'b0;
        i_ack   = 4'b0000;
        cyc();
        reset_n = 1'b0;
        i_ack   = 4'b1111;
        t_mask  = 4'b1111;
        t_req   = 1'b1;
        // After edge i+1 exactly i tokens have completed.
        for (int i = 0; i < 17; i++) begin
            t_data = 32'h100 + 32'(i);
            cyc();
            exp_w = 4'(i);
            checks++; if (s_tok_cnt !== exp_w) begin errors++; $display("FAIL wr_small_tok[%0d] got=%0d exp=%0d", i, s_tok_cnt, exp_w); end
            checks++; if (tok_cnt !== 16'(i)) begin errors++; $display("FAIL wr_tok[%0d] got=%0d exp=%0d", i, tok_cnt, i); end
            $display("wrap %0d: small_tok=%0d tok=%0d", i, s_tok_cnt, tok_cnt);
        end
        t_req = 1'b0;
        cyc();
        checks++; if (s_tok_cnt !== 4'd1) begin errors++; $display("FAIL wr_small_end got=%0d exp=1", s_tok_cnt); end
        checks++; if (tok_cnt !== 16'd17) begin errors++; $display("FAIL wr_tok_end got=%0d exp=17", tok_cnt); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL wr_small_busy got=%b exp=0", s_busy); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_staggered();
        test_mask_partial();
        test_drop();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so a stuck run still terminates with a report.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
